// File: rtl/jw_collect_if.sv
// jw_collect_if
//   Bus between the Julia workers / frame buffer and the result collector.
//   Parameters: NUM_WORKERS (result ports), COLOR_W (pixel colour width).
//   Worker side : jw_cl_valid, jw_cl_x, jw_cl_y, jw_cl_color -> collector
//                 cl_jw_ack                                  <- collector
//   Frame buffer: fb_wr_en, fb_addr, fb_data                 <- collector
//                 fb_ready                                   -> collector
//   Modports: master = workers + frame buffer, slave = collector.
//
// Handshakes: a worker raises jw_cl_valid[w] with stable x/y/color and holds it
// until cl_jw_ack[w] pulses for one cycle; the result transfers on the clock
// edge before that ack pulse. A frame-buffer write transfers on every rising
// edge where fb_wr_en and fb_ready are both high; while fb_wr_en is high and
// fb_ready is low, fb_addr/fb_data hold stable.
interface jw_collect_if #(
  parameter int NUM_WORKERS = 16,
  parameter int COLOR_W     = 8
);
  logic [NUM_WORKERS-1:0]              jw_cl_valid;
  logic [NUM_WORKERS-1:0][9:0]         jw_cl_x;
  logic [NUM_WORKERS-1:0][9:0]         jw_cl_y;
  logic [NUM_WORKERS-1:0][COLOR_W-1:0] jw_cl_color;
  logic [NUM_WORKERS-1:0]              cl_jw_ack;
  logic                                fb_wr_en;
  logic [18:0]                         fb_addr;
  logic [COLOR_W-1:0]                  fb_data;
  logic                                fb_ready;

  modport master (
    output jw_cl_valid, jw_cl_x, jw_cl_y, jw_cl_color, fb_ready,
    input  cl_jw_ack, fb_wr_en, fb_addr, fb_data
  );

  modport slave (
    input  jw_cl_valid, jw_cl_x, jw_cl_y, jw_cl_color, fb_ready,
    output cl_jw_ack, fb_wr_en, fb_addr, fb_data
  );
endinterface

// File: rtl/jw_collect.sv
// jw_collect
//   Result collector for the Julia renderer. Accepts finished pixels from
//   NUM_WORKERS workers with a round-robin arbiter, buffers them in a
//   show-ahead FIFO and writes them to the frame buffer at y*640+x. Signals
//   frame_done once FRAME_PIX results have been collected and written.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     start      : begin a new frame (sampled in IDLE only)
//     bus        : jw_collect_if.slave (worker handshake + frame-buffer write)
//     pix_count  : in-range results accepted this frame
//     frame_done : one-cycle pulse in the DONE state
//     err_oob    : sticky out-of-range flag
//     state_dbg  : current FSM state (IDLE=0, COLLECT=1, FLUSH=2, DONE=3)
//   Optional feature: define JW_COLLECT_OOB_CHECK_EN to drop results with
//   x > 639 or y > 479 (still acked) and flag them on err_oob.
module jw_collect #(
  parameter int NUM_WORKERS = 16,
  parameter int COLOR_W     = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_PIX   = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  jw_collect_if.slave bus,
  output logic [18:0] pix_count,
  output logic        frame_done,
  output logic        err_oob,
  output logic [1:0]  state_dbg
);
  localparam int PTR_W = $clog2(NUM_WORKERS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr;      // first worker searched next cycle
  logic [NUM_WORKERS-1:0] ack_q;
  logic [NUM_WORKERS-1:0] eligible;
  logic [PTR_W-1:0]       cand;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_valid;
  logic                   gnt_oob;
  logic [9:0]             sel_x, sel_y;
  logic [18:0]            x_ext, y_ext, gnt_addr;

  logic [18:0]            mem_addr [FIFO_DEPTH];
  logic [COLOR_W-1:0]     mem_data [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          fifo_cnt, fifo_cnt_nxt;
  logic                   push, pop, wr_en;

  // Round-robin search starting at rr_ptr. The worker acked this cycle is
  // excluded because its valid is still high while it sees the ack. The
  // full check uses the current count only, so a same-cycle pop never frees
  // room early.
  always_comb begin
    eligible  = bus.jw_cl_valid & ~ack_q;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      cand = rr_ptr + PTR_W'(i);
      if (state == S_COLLECT && fifo_cnt < CW'(FIFO_DEPTH) &&
          !gnt_valid && eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign sel_x    = bus.jw_cl_x[gnt_idx];
  assign sel_y    = bus.jw_cl_y[gnt_idx];
  assign x_ext    = {9'd0, sel_x};
  assign y_ext    = {9'd0, sel_y};
  // y*640 = y*512 + y*128; wraps mod 2^19 for out-of-range coordinates.
  assign gnt_addr = (y_ext << 9) + (y_ext << 7) + x_ext;

`ifdef JW_COLLECT_OOB_CHECK_EN
  assign gnt_oob = (sel_x > 10'd639) || (sel_y > 10'd479);

  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_q <= 1'b0;
    else if (state == S_IDLE && start)    err_q <= 1'b0;
    else if (gnt_valid && gnt_oob)        err_q <= 1'b1;
  end
  assign err_oob = err_q;
`else
  assign gnt_oob = 1'b0;
  assign err_oob = 1'b0;
`endif

  assign push         = gnt_valid && !gnt_oob;
  assign wr_en        = (fifo_cnt != '0) && (state == S_COLLECT || state == S_FLUSH);
  assign pop          = wr_en && bus.fb_ready;
  assign fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop);

  assign bus.fb_wr_en  = wr_en;
  assign bus.fb_addr   = wr_en ? mem_addr[rd_ptr] : '0;
  assign bus.fb_data   = wr_en ? mem_data[rd_ptr] : '0;
  assign bus.cl_jw_ack = ack_q;
  assign frame_done    = (state == S_DONE);
  assign state_dbg     = state;

  // Leaving COLLECT on the same edge as the final push, and leaving FLUSH on
  // the edge of the final pop, puts DONE exactly one cycle after that pop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (push && pix_count == 19'(FRAME_PIX - 1)) state_nxt = S_FLUSH;
      S_FLUSH:   if (fifo_cnt_nxt == '0) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      ack_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      pix_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      ack_q <= '0;
      if (gnt_valid) begin
        ack_q[gnt_idx] <= 1'b1;
        rr_ptr         <= gnt_idx + PTR_W'(1);
      end
      if (state == S_IDLE && start) pix_count <= '0;
      else if (push)                pix_count <= pix_count + 19'd1;
      if (push) begin
        mem_addr[wr_ptr] <= gnt_addr;
        mem_data[wr_ptr] <= bus.jw_cl_color[gnt_idx];
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_jw_collect.sv
// tb_jw_collect
//   Directed bench for jw_collect. Two instances share the worker stimulus:
//   dut_a uses the full 640x480 frame, dut_b has FRAME_PIX = 8 for the
//   end-of-frame sequence. sel chooses which instance gets start and is
//   observed; the other stays in IDLE and ignores the workers.
module tb_jw_collect;
  localparam int NW = 16;
  localparam int CW = 8;
`ifdef JW_COLLECT_OOB_CHECK_EN
  localparam bit OOB = 1'b1;
`else
  localparam bit OOB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   start, sel, fb_ready;
  logic [NW-1:0]          valid;
  logic [NW-1:0][9:0]     wx, wy;
  logic [NW-1:0][CW-1:0]  wc;

  jw_collect_if #(.NUM_WORKERS(NW), .COLOR_W(CW)) if_a ();
  jw_collect_if #(.NUM_WORKERS(NW), .COLOR_W(CW)) if_b ();

  assign if_a.jw_cl_valid = valid;
  assign if_a.jw_cl_x     = wx;
  assign if_a.jw_cl_y     = wy;
  assign if_a.jw_cl_color = wc;
  assign if_a.fb_ready    = fb_ready;
  assign if_b.jw_cl_valid = valid;
  assign if_b.jw_cl_x     = wx;
  assign if_b.jw_cl_y     = wy;
  assign if_b.jw_cl_color = wc;
  assign if_b.fb_ready    = fb_ready;

  logic        start_a, start_b;
  logic [18:0] pix_a, pix_b;
  logic        done_a, done_b, err_a, err_b;
  logic [1:0]  st_a, st_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  jw_collect #(.NUM_WORKERS(NW), .COLOR_W(CW), .FIFO_DEPTH(4), .FRAME_PIX(307200)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(if_a),
    .pix_count(pix_a), .frame_done(done_a), .err_oob(err_a), .state_dbg(st_a)
  );
  jw_collect #(.NUM_WORKERS(NW), .COLOR_W(CW), .FIFO_DEPTH(4), .FRAME_PIX(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(if_b),
    .pix_count(pix_b), .frame_done(done_b), .err_oob(err_b), .state_dbg(st_b)
  );

  logic [NW-1:0] ack;
  logic          wr_en, done, err;
  logic [18:0]   addr, pix;
  logic [CW-1:0] data;
  logic [1:0]    st;
  assign ack   = sel ? if_b.cl_jw_ack : if_a.cl_jw_ack;
  assign wr_en = sel ? if_b.fb_wr_en  : if_a.fb_wr_en;
  assign addr  = sel ? if_b.fb_addr   : if_a.fb_addr;
  assign data  = sel ? if_b.fb_data   : if_a.fb_data;
  assign pix   = sel ? pix_b  : pix_a;
  assign done  = sel ? done_b : done_a;
  assign err   = sel ? err_b  : err_a;
  assign st    = sel ? st_b   : st_a;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [26:0]   exp_q[$];
  int            ack_total;
  logic [NW-1:0] ack_seen, last_ack;
  logic          popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic expect_write(input int x, input int y, input logic [CW-1:0] c);
    int a;
    a = (y * 640 + x) % 524288;
    exp_q.push_back({a[18:0], c});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already set: a write accepted at the
  // coming rising edge is scored, then worker valids drop when acked.
  task automatic cycle();
    logic [26:0] e;
    popped = wr_en && fb_ready;
    if (popped) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("fb_write", {5'd0, addr, data}, {5'd0, e});
    end
    @(negedge clk);
    last_ack = ack;
    for (int w = 0; w < NW; w++) begin
      if (ack[w]) begin
        valid[w] = 1'b0;
        ack_total++;
      end
    end
    ack_seen = ack_seen | ack;
  endtask

  task automatic do_reset(input logic s);
    sel = s; rst = 1'b1; start = 1'b0; fb_ready = 1'b1;
    valid = '0; wx = '0; wy = '0; wc = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_total = 0; ack_seen = '0; last_ack = '0;
  endtask

  task automatic set_worker(input int w, input int x, input int y, input logic [CW-1:0] c);
    wx[w] = 10'(x); wy[w] = 10'(y); wc[w] = c; valid[w] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pop_it, done_it, done_cnt, needed;
    logic saw_flush;

    // Reset values and single-result latency.
    do_reset(1'b0);
    check("rst_ack", 32'(ack), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_data", 32'(data), 0);
    check("rst_pix", 32'(pix), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_state", 32'(st), 0);

    set_worker(3, 5, 2, 8'h7A);
    expect_write(5, 2, 8'h7A);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("t1_ack", 32'(last_ack), 32'h0008);
    check("t1_wr_en", 32'(wr_en), 1);
    check("t1_addr", 32'(addr), 1285);
    check("t1_data", 32'(data), 32'h7A);
    check("t1_pix", 32'(pix), 1);
    cycle();
    check("t1_ack_gone", 32'(ack), 0);
    check("t1_wr_done", 32'(wr_en), 0);

    // Round-robin across all 16 workers.
    do_reset(1'b0);
    for (int w = 0; w < NW; w++) begin
      set_worker(w, w * 40 + 3, w * 30 + 1, 8'(w * 17));
      expect_write(w * 40 + 3, w * 30 + 1, 8'(w * 17));
    end
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      cycle();
      check($sformatf("rr_ack%0d", i), 32'(last_ack), 32'd1 << i);
    end
    cycle();
    check("rr_quiet", 32'(last_ack), 0);
    for (int w = 0; w < NW; w++) begin
      valid[w] = 1'b1;
      expect_write(w * 40 + 3, w * 30 + 1, 8'(w * 17));
    end
    cycle();
    check("rr_resume0", 32'(last_ack), 1);
    repeat (20) cycle();
    check("rr_total", 32'(ack_total), 32);
    check("rr_pix", 32'(pix), 32);
    check("rr_sb_empty", 32'(exp_q.size()), 0);

    // Back-pressure: FIFO of 4 fills, then drains in order.
    do_reset(1'b0);
    fb_ready = 1'b0;
    for (int w = 0; w < 6; w++) begin
      set_worker(w, 100 + w, 10 + w, 8'(8'hA0 + w));
      expect_write(100 + w, 10 + w, 8'(8'hA0 + w));
    end
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    check("bp_acks", 32'(ack_total), 4);
    check("bp_wr_en", 32'(wr_en), 1);
    check("bp_addr_hold", 32'(addr), 6500);
    check("bp_data_hold", 32'(data), 32'hA0);
    fb_ready = 1'b1;
    repeat (12) cycle();
    check("bp_acks_all", 32'(ack_total), 6);
    check("bp_pix", 32'(pix), 6);
    check("bp_sb_empty", 32'(exp_q.size()), 0);

    // Corner and out-of-range addresses.
    do_reset(1'b0);
    set_worker(0, 639, 479, 8'h11);
    set_worker(1, 0, 0, 8'h22);
    set_worker(2, 640, 0, 8'h33);
    set_worker(3, 1023, 1023, 8'h44);
    expect_write(639, 479, 8'h11);
    expect_write(0, 0, 8'h22);
    if (!OOB) begin
      expect_write(640, 0, 8'h33);
      expect_write(1023, 1023, 8'h44);
    end
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("corner_max", 32'(addr), 307199);
    cycle();
    check("corner_zero", 32'(addr), 0);
    cycle();
    check("oob_640_wr", 32'(wr_en), OOB ? 0 : 1);
    check("oob_640_addr", 32'(addr), OOB ? 0 : 640);
    cycle();
    check("wrap_addr", 32'(addr), OOB ? 0 : 131455);
    repeat (6) cycle();
    check("oob_acks", 32'(ack_total), 4);
    check("oob_pix", 32'(pix), OOB ? 2 : 4);
    check("oob_err", 32'(err), OOB ? 1 : 0);
    check("oob_sb_empty", 32'(exp_q.size()), 0);

    // Full frame on the FRAME_PIX=8 instance.
    do_reset(1'b1);
    set_worker(0, 640, 0, 8'h55);
    if (!OOB) expect_write(640, 0, 8'h55);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    check("fr_oob_ack", 32'(last_ack), 1);
    check("fr_oob_pix", 32'(pix), OOB ? 0 : 1);
    check("fr_oob_err", 32'(err), OOB ? 1 : 0);
    needed = OOB ? 8 : 7;
    for (int w = 1; w <= needed; w++) begin
      set_worker(w, w * 8, w * 4, 8'(w));
      expect_write(w * 8, w * 4, 8'(w));
    end
    set_worker(15, 1, 1, 8'hEE);
    pop_it = -1; done_it = -1; done_cnt = 0; saw_flush = 1'b0;
    for (int it = 0; it < 40; it++) begin
      cycle();
      if (popped) pop_it = it;
      if (st == 2'd2) saw_flush = 1'b1;
      if (done) begin
        done_cnt++;
        done_it = it;
        check("fr_done_state", 32'(st), 3);
      end
    end
    check("fr_saw_flush", 32'(saw_flush), 1);
    check("fr_done_once", 32'(done_cnt), 1);
    check("fr_done_after_pop", 32'(done_it), 32'(pop_it));
    check("fr_idle", 32'(st), 0);
    check("fr_pix", 32'(pix), 8);
    check("fr_no_ninth", 32'(ack_seen[15]), 0);
    check("fr_acks", 32'(ack_total), 32'(needed + 1));
    check("fr_sb_empty", 32'(exp_q.size()), 0);

    // Next start clears err_oob; then reset mid-frame.
    start = 1'b1; cycle(); start = 1'b0;
    check("fr_err_clear", 32'(err), 0);
    check("fr_restart", 32'(st), 1);
    fb_ready = 1'b0;
    set_worker(2, 2, 2, 8'h66);
    repeat (3) cycle();
    check("mid_wr_en", 32'(wr_en), 1);
    check("mid_pix", 32'(pix), 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_addr", 32'(addr), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_pix", 32'(pix), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_state", 32'(st), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
